dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
Data-memory access controller sitting directly downstream of the pipeline MEM stage. Converts the MEM stage's single-cycle ren/wen/addr/dout interface into a req/ack handshake toward a multi-cycle data RAM. Asserts a stall back to the pipeline controller until each access completes, and returns read data on mem_din. Flags misaligned and timed-out accesses.

Parameters:
ADDR_WIDTH, 32, byte address width from the MEM stage
DATA_WIDTH, 32, data word width
TIMEOUT, 15, maximum cycles ram_req may stay high without ram_ack before the access is aborted (>=1)

Ports:
clk  in  1  clock; one clock domain, all state on rising edge
rst_n  in  1  synchronous, active-low reset
mem_ren  in  1  MEM-stage read enable
mem_wen  in  1  MEM-stage write enable; has priority over mem_ren if both are high
mem_addr  in  ADDR_WIDTH  byte address (ALU result of the MEM stage)
mem_dout  in  DATA_WIDTH  store data from the MEM stage
mem_din  out  DATA_WIDTH  load data to the MEM/WB register
mem_stall  out  1  high = hold MEM and all upstream stages
mem_err  out  1  one-cycle pulse: misaligned access or timeout
ram_req  out  1  registered request; held until ram_ack or timeout
ram_we  out  1  registered write flag
ram_addr  out  ADDR_WIDTH-2  registered word address (mem_addr[ADDR_WIDTH-1:2])
ram_wdata  out  DATA_WIDTH  registered write data
ram_ack  in  1  one-cycle completion strobe from the RAM
ram_rdata  in  DATA_WIDTH  read data; valid in the ram_ack cycle

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; ram_req=0, ram_we=0, ram_addr=0, ram_wdata=0; timeout counter=0; read-data register=0. A reset mid-access abandons the access, and ram_req is low after that edge.
- The states are IDLE, BUSY, DONE and ERR.
- IDLE:
  - No access: mem_stall=0, mem_din=0, mem_err=0.
  - Access with mem_addr[1:0]!=0: go to ERR. No RAM request. mem_stall=1 in this cycle.
  - Aligned access: mem_stall=1 combinationally in the same cycle. At the edge, latch ram_req=1, ram_we=mem_wen, ram_addr, ram_wdata=mem_dout; go to BUSY; counter=0.
- BUSY:
  - mem_stall=1 and ram_req=1.
  - ram_ack=1: latch ram_rdata (reads only), clear ram_req, go to DONE.
  - Otherwise counter++. When counter==TIMEOUT-1 and still no ack: clear ram_req, go to ERR.
- DONE:
  - mem_stall=0; mem_din=the latched read data (0 for writes).
  - The pipeline advances at the end of this cycle. Next state is always IDLE.
  - The MEM-stage inputs, which still show the finished access, are ignored, so there is no reissue.
- ERR:
  - mem_stall=0, mem_err=1, mem_din=0. Next state is IDLE.
- Latency: an aligned access takes 1 (IDLE) + N (BUSY, ack in its Nth cycle) + 1 (DONE) cycles. The best case, with ack in the first BUSY cycle, is 3 cycles.
- ram_ack outside BUSY is ignored, including a late ack after a timeout.
- ram_* outputs stay stable while ram_req=1.
- mem_err is high only in ERR.

Optional Feature:
DMEM_RDBUF_EN
- Defined: adds a single-entry read buffer holding a tag, data and a valid bit.
  - Fill: in DONE after a read.
  - Hit: in IDLE, an aligned read whose word address equals the tag while valid. It completes in zero cycles: mem_din=buffer data, mem_stall=0, no RAM request, state stays IDLE.
  - Any write to the tagged word updates the buffer data when the write reaches DONE.
  - Reset clears valid.
- Undefined: no buffer; every access goes through BUSY.

Decomposition:
- Shared package dmem_pkg: state encoding (IDLE/BUSY/DONE/ERR) and default TIMEOUT.
- Optional sub-module dmem_rdbuf: the tag/data/valid register with hit compare, instantiated only under DMEM_RDBUF_EN.

Test Plan:
1. Aligned read 0x10, RAM acks on the 2nd BUSY cycle with 0xDEADBEEF -> mem_stall high 3 cycles; DONE cycle mem_din=0xDEADBEEF, mem_stall=0; ram_req high for exactly 2 cycles.
2. Write 0x20 with data 0x12345678 -> ram_we=1, ram_addr=0x8, ram_wdata=0x12345678 held until ack; mem_din=0 in DONE.
3. Read at 0x13 -> no ram_req; mem_err=1 for one cycle; mem_stall=1 for one cycle then 0.
4. Read with ram_ack never asserted, TIMEOUT=15 -> ram_req high 15 cycles then drops; mem_err pulses once; a late ack later has no effect.
5. rst_n=0 during BUSY -> next cycle state IDLE, ram_req=0, mem_stall=0 with no access presented.
6. With DMEM_RDBUF_EN, read 0x40 twice back-to-back -> the second completes with mem_stall=0 and no ram_req. A write to 0x40 with data 0x55, then a read -> returns 0x55 with no ram_req.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory access controller.
//   dmem_state_e     : controller state encoding (IDLE/BUSY/DONE/ERR)
//   DMEM_TIMEOUT_DEF : default cycles a RAM request may wait for ram_ack
//   cnt_width()      : width of a counter that must reach t-1
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } dmem_state_e;

  localparam int DMEM_TIMEOUT_DEF = 15;

  function automatic int cnt_width(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// dmem_if: MEM-stage bus plus RAM request/ack bus of the data-memory controller.
//   MEM side : mem_ren, mem_wen, mem_addr, mem_dout (to ctrl)
//              mem_din, mem_stall, mem_err         (from ctrl)
//   RAM side : ram_req, ram_we, ram_addr, ram_wdata (from ctrl)
//              ram_ack, ram_rdata                  (to ctrl)
// modport master = controller view, modport slave = pipeline/RAM view.
interface dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_ren;
  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic [DATA_WIDTH-1:0] mem_din;
  logic                  mem_stall;
  logic                  mem_err;
  logic                  ram_req;
  logic                  ram_we;
  logic [ADDR_WIDTH-3:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  ram_ack;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport master (
    input  mem_ren, mem_wen, mem_addr, mem_dout, ram_ack, ram_rdata,
    output mem_din, mem_stall, mem_err, ram_req, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    output mem_ren, mem_wen, mem_addr, mem_dout, ram_ack, ram_rdata,
    input  mem_din, mem_stall, mem_err, ram_req, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/dmem_rdbuf.sv
// dmem_rdbuf: single-entry read buffer (tag, data, valid) with hit compare.
// Only built when DMEM_RDBUF_EN is defined.
//   clk, rst_n : clock, synchronous active-low reset (clears valid)
//   lk_addr_i  : word address to look up; hit_o/data_o are combinational
//   fill_i     : load tag=wr_addr_i, data=wr_data_i, set valid
//   upd_i      : overwrite data if valid and tag matches wr_addr_i
`ifdef DMEM_RDBUF_EN
module dmem_rdbuf #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] lk_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o,
  input  logic          fill_i,
  input  logic          upd_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);
  logic          vld_q, vld_d;
  logic [AW-1:0] tag_q, tag_d;
  logic [DW-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (fill_i) begin
      vld_d  = 1'b1;
      tag_d  = wr_addr_i;
      data_d = wr_data_i;
    end else if (upd_i && vld_q && (tag_q == wr_addr_i)) begin
      data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  assign hit_o  = vld_q && (tag_q == lk_addr_i);
  assign data_o = data_q;
endmodule
`endif

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: turns the MEM stage's single-cycle ren/wen interface into a
// req/ack handshake toward a multi-cycle data RAM, stalling the pipeline
// until each access completes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : dmem_if.master (MEM-stage bus + RAM bus)
// Optional: DMEM_RDBUF_EN adds a one-entry read buffer; aligned reads that
// hit it complete in IDLE with no stall and no RAM request.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = DMEM_TIMEOUT_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  dmem_if.master bus
);
  localparam int            WAW      = ADDR_WIDTH - 2;
  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  dmem_state_e           state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [WAW-1:0]        addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  access, aligned, buf_hit;
  logic [DATA_WIDTH-1:0] buf_data, din_c;
  logic                  stall_c, err_c;

  assign access  = bus.mem_wen | bus.mem_ren;
  assign aligned = (bus.mem_addr[1:0] == 2'b00);

`ifdef DMEM_RDBUF_EN
  logic buf_tag_hit;

  // Reads fill from the latched RAM data; writes refresh a matching entry
  // so a later hit never returns stale data.
  dmem_rdbuf #(.AW(WAW), .DW(DATA_WIDTH)) u_rdbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_addr_i (bus.mem_addr[ADDR_WIDTH-1:2]),
    .hit_o     (buf_tag_hit),
    .data_o    (buf_data),
    .fill_i    ((state_q == ST_DONE) && !we_q),
    .upd_i     ((state_q == ST_DONE) && we_q),
    .wr_addr_i (addr_q),
    .wr_data_i (we_q ? wdata_q : rdata_q)
  );

  // Write has priority, so a simultaneous ren/wen is never a hit.
  assign buf_hit = buf_tag_hit & bus.mem_ren & ~bus.mem_wen & aligned;
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    din_c   = '0;
    err_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (!aligned) begin
            stall_c = 1'b1;
            state_d = ST_ERR;
          end else if (buf_hit) begin
            din_c = buf_data;
          end else begin
            stall_c = 1'b1;
            req_d   = 1'b1;
            we_d    = bus.mem_wen;
            addr_d  = bus.mem_addr[ADDR_WIDTH-1:2];
            wdata_d = bus.mem_dout;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        stall_c = 1'b1;
        if (bus.ram_ack) begin
          if (!we_q) rdata_d = bus.ram_rdata;
          req_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // MEM inputs still show the finished access here; they are ignored so
      // the access is not reissued.
      ST_DONE: begin
        din_c   = we_q ? '0 : rdata_q;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err_c   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_din   = din_c;
  assign bus.mem_stall = stall_c;
  assign bus.mem_err   = err_c;
  assign bus.ram_req   = req_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: self-checking bench for dmem_ctrl. A RAM responder acks
// after a chosen number of request cycles; a transaction-level model
// (memory array + optional buffer tag) predicts stall/req/err/din per access.
module tb_dmem_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  dmem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    int          stall_cyc;
    int          req_cyc;
    int          err_cyc;
    logic [31:0] din;
    bit          ram_ok;
    bit          done;
  } obs_t;

  int n_chk = 0;
  int n_pass = 0;

  logic [31:0] ram_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
`ifdef DMEM_RDBUF_EN
  bit          bvalid = 1'b0;
  int unsigned btag = 0;
`endif

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  function automatic logic [31:0] ram_rd(input int unsigned w);
    return ram_mem.exists(w) ? ram_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // Reference: outcome of one access from the block's rules, plus state update.
  function automatic void model_access(input bit we, input logic [31:0] addr,
      input logic [31:0] wd, input int ack, output int e_stall, output int e_req,
      output int e_err, output logic [31:0] e_din);
    int unsigned w;
    bit hit;
    w   = addr >> 2;
    hit = 1'b0;
`ifdef DMEM_RDBUF_EN
    hit = !we && bvalid && (btag == w);
`endif
    if (addr[1:0] != 2'b00) begin
      e_stall = 1; e_req = 0; e_err = 1; e_din = '0;
    end else if (hit) begin
      e_stall = 0; e_req = 0; e_err = 0; e_din = ref_rd(w);
    end else if (ack >= 1 && ack <= TO) begin
      e_stall = ack + 1; e_req = ack; e_err = 0;
      e_din = we ? 32'h0 : ref_rd(w);
      if (we) ref_mem[w] = wd;
`ifdef DMEM_RDBUF_EN
      else begin bvalid = 1'b1; btag = w; end
`endif
    end else begin
      e_stall = TO + 1; e_req = TO; e_err = 1; e_din = '0;
    end
  endfunction

  // Presents one access and plays the RAM: acks in the ack-th cycle that
  // ram_req is seen high (ack=0: never). Ends at the first unstalled cycle.
  task automatic run_access(input bit we, input logic [31:0] addr,
      input logic [31:0] wd, input int ack, output obs_t o);
    int  reqn;
    bit  fin;
    o = '{default: 0};
    o.ram_ok = 1'b1;
    reqn = 0;
    fin  = 1'b0;
    @(negedge clk);
    bif.mem_wen  = we;
    bif.mem_ren  = !we;
    bif.mem_addr = addr;
    bif.mem_dout = wd;
    bif.ram_ack  = 1'b0;
    for (int c = 0; c < TO + 8 && !fin; c++) begin
      if (c > 0) begin
        @(negedge clk);
        bif.ram_ack   = 1'b0;
        bif.ram_rdata = $urandom;
      end
      #1;
      if (bif.mem_stall === 1'b1) o.stall_cyc++;
      if (bif.mem_err === 1'b1) o.err_cyc++;
      if (bif.ram_req === 1'b1) begin
        o.req_cyc++;
        reqn++;
        if (bif.ram_we !== we || bif.ram_addr !== addr[31:2] || bif.ram_wdata !== wd)
          o.ram_ok = 1'b0;
        if (reqn == ack) begin
          bif.ram_ack = 1'b1;
          if (bif.ram_we) ram_mem[32'(bif.ram_addr)] = bif.ram_wdata;
          else bif.ram_rdata = ram_rd(32'(bif.ram_addr));
        end
      end
      if (bif.mem_stall === 1'b0) begin
        fin    = 1'b1;
        o.done = 1'b1;
        o.din  = bif.mem_din;
      end
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bif.mem_ren = 1'b0;
    bif.mem_wen = 1'b0;
    bif.ram_ack = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bif.mem_ren = 0; bif.mem_wen = 0; bif.mem_addr = '0; bif.mem_dout = '0;
    bif.ram_ack = 0; bif.ram_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_chk++;
    if ({bif.ram_req, bif.ram_we, bif.mem_stall, bif.mem_err} !== 4'b0)
      $display("FAIL reset_ctl got req=%b we=%b stall=%b err=%b exp 0", bif.ram_req,
               bif.ram_we, bif.mem_stall, bif.mem_err);
    else n_pass++;
    n_chk++;
    if (bif.ram_addr !== '0 || bif.ram_wdata !== '0 || bif.mem_din !== '0)
      $display("FAIL reset_data got addr=%h wdata=%h din=%h exp 0", bif.ram_addr,
               bif.ram_wdata, bif.mem_din);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_read();
    obs_t o; int es, er, ee; logic [31:0] ed;
    ram_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    model_access(0, 32'h10, 32'h0, 2, es, er, ee, ed);
    run_access(0, 32'h10, 32'h0, 2, o);
    n_chk++;
    if (o.stall_cyc !== 3) $display("FAIL rd_stall got %0d exp 3", o.stall_cyc); else n_pass++;
    n_chk++;
    if (o.req_cyc !== 2) $display("FAIL rd_req got %0d exp 2", o.req_cyc); else n_pass++;
    n_chk++;
    if (o.din !== 32'hDEADBEEF) $display("FAIL rd_din got %h exp deadbeef", o.din); else n_pass++;
    n_chk++;
    if (!o.ram_ok || o.err_cyc !== 0) $display("FAIL rd_bus got ok=%0d err=%0d exp 1/0", o.ram_ok, o.err_cyc);
    else n_pass++;
  endtask

  task automatic test_write();
    obs_t o; int es, er, ee; logic [31:0] ed;
    model_access(1, 32'h20, 32'h12345678, 3, es, er, ee, ed);
    run_access(1, 32'h20, 32'h12345678, 3, o);
    n_chk++;
    if (o.req_cyc !== 3 || o.stall_cyc !== 4)
      $display("FAIL wr_cyc got req=%0d stall=%0d exp 3/4", o.req_cyc, o.stall_cyc);
    else n_pass++;
    n_chk++;
    if (!o.ram_ok) $display("FAIL wr_bus got ram_ok=0 exp 1"); else n_pass++;
    n_chk++;
    if (o.din !== 32'h0) $display("FAIL wr_din got %h exp 0", o.din); else n_pass++;
    n_chk++;
    if (ram_rd(8) !== 32'h12345678) $display("FAIL wr_ram got %h exp 12345678", ram_rd(8));
    else n_pass++;
  endtask

  task automatic test_misaligned();
    obs_t o; int es, er, ee; logic [31:0] ed;
    model_access(0, 32'h13, 32'h0, 1, es, er, ee, ed);
    run_access(0, 32'h13, 32'h0, 1, o);
    n_chk++;
    if (o.stall_cyc !== 1 || o.req_cyc !== 0)
      $display("FAIL mis_cyc got stall=%0d req=%0d exp 1/0", o.stall_cyc, o.req_cyc);
    else n_pass++;
    n_chk++;
    if (o.err_cyc !== 1 || o.din !== 32'h0)
      $display("FAIL mis_err got err=%0d din=%h exp 1/0", o.err_cyc, o.din);
    else n_pass++;
    idle_cycle();
    n_chk++;
    if (bif.mem_err !== 1'b0 || bif.mem_stall !== 1'b0 || bif.ram_req !== 1'b0)
      $display("FAIL mis_after got err=%b stall=%b req=%b exp 0", bif.mem_err, bif.mem_stall, bif.ram_req);
    else n_pass++;
  endtask

  task automatic test_timeout();
    obs_t o; int es, er, ee; logic [31:0] ed;
    model_access(0, 32'h50, 32'h0, 0, es, er, ee, ed);
    run_access(0, 32'h50, 32'h0, 0, o);
    n_chk++;
    if (o.req_cyc !== TO || o.stall_cyc !== TO + 1)
      $display("FAIL to_cyc got req=%0d stall=%0d exp %0d/%0d", o.req_cyc, o.stall_cyc, TO, TO + 1);
    else n_pass++;
    n_chk++;
    if (o.err_cyc !== 1 || o.din !== 32'h0 || !o.done)
      $display("FAIL to_err got err=%0d din=%h done=%0d exp 1/0/1", o.err_cyc, o.din, o.done);
    else n_pass++;
    // late ack with nothing outstanding
    @(negedge clk);
    bif.mem_ren = 0; bif.mem_wen = 0;
    bif.ram_ack = 1'b1; bif.ram_rdata = 32'hBAD0BAD0;
    #1;
    n_chk++;
    if ({bif.ram_req, bif.mem_stall, bif.mem_err} !== 3'b0 || bif.mem_din !== '0)
      $display("FAIL to_late got req=%b stall=%b err=%b din=%h exp 0", bif.ram_req,
               bif.mem_stall, bif.mem_err, bif.mem_din);
    else n_pass++;
    idle_cycle();
    n_chk++;
    if ({bif.ram_req, bif.mem_stall, bif.mem_err} !== 3'b0 || bif.mem_din !== '0)
      $display("FAIL to_late2 got req=%b stall=%b err=%b din=%h exp 0", bif.ram_req,
               bif.mem_stall, bif.mem_err, bif.mem_din);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bif.mem_ren = 1; bif.mem_wen = 0; bif.mem_addr = 32'h30; bif.ram_ack = 0;
    @(negedge clk);
    #1;
    n_chk++;
    if (bif.ram_req !== 1'b1) $display("FAIL rstmid_busy got req=%b exp 1", bif.ram_req); else n_pass++;
    rst_n = 1'b0;
    bif.mem_ren = 0;
    @(negedge clk);
    #1;
    n_chk++;
    if (bif.ram_req !== 1'b0 || bif.mem_stall !== 1'b0 || bif.ram_addr !== '0)
      $display("FAIL rstmid got req=%b stall=%b addr=%h exp 0", bif.ram_req, bif.mem_stall, bif.ram_addr);
    else n_pass++;
    rst_n = 1'b1;
`ifdef DMEM_RDBUF_EN
    bvalid = 1'b0;
`endif
    idle_cycle();
    n_chk++;
    if (bif.ram_req !== 1'b0 || bif.mem_stall !== 1'b0)
      $display("FAIL rstmid_idle got req=%b stall=%b exp 0", bif.ram_req, bif.mem_stall);
    else n_pass++;
  endtask

`ifdef DMEM_RDBUF_EN
  task automatic test_rdbuf();
    obs_t o; int es, er, ee; logic [31:0] ed;
    model_access(0, 32'h40, 32'h0, 1, es, er, ee, ed);
    run_access(0, 32'h40, 32'h0, 1, o);
    n_chk++;
    if (o.req_cyc !== 1 || o.din !== ed)
      $display("FAIL buf_fill got req=%0d din=%h exp 1/%h", o.req_cyc, o.din, ed);
    else n_pass++;
    model_access(0, 32'h40, 32'h0, 1, es, er, ee, ed);
    run_access(0, 32'h40, 32'h0, 1, o);
    n_chk++;
    if (o.req_cyc !== 0 || o.stall_cyc !== 0 || o.din !== init_word(32'h10))
      $display("FAIL buf_hit got req=%0d stall=%0d din=%h exp 0/0/%h", o.req_cyc,
               o.stall_cyc, o.din, init_word(32'h10));
    else n_pass++;
    model_access(1, 32'h40, 32'h55, 2, es, er, ee, ed);
    run_access(1, 32'h40, 32'h55, 2, o);
    n_chk++;
    if (o.req_cyc !== 2) $display("FAIL buf_wr got req=%0d exp 2", o.req_cyc); else n_pass++;
    model_access(0, 32'h40, 32'h0, 1, es, er, ee, ed);
    run_access(0, 32'h40, 32'h0, 1, o);
    n_chk++;
    if (o.req_cyc !== 0 || o.stall_cyc !== 0 || o.din !== 32'h55)
      $display("FAIL buf_upd got req=%0d stall=%0d din=%h exp 0/0/55", o.req_cyc, o.stall_cyc, o.din);
    else n_pass++;
  endtask
`else
  task automatic test_no_rdbuf();
    obs_t o; int es, er, ee; logic [31:0] ed;
    for (int k = 0; k < 2; k++) begin
      model_access(0, 32'h40, 32'h0, 1, es, er, ee, ed);
      run_access(0, 32'h40, 32'h0, 1, o);
      n_chk++;
      if (o.req_cyc !== 1 || o.stall_cyc !== 2 || o.din !== init_word(32'h10))
        $display("FAIL nobuf_rd%0d got req=%0d stall=%0d din=%h exp 1/2/%h", k, o.req_cyc,
                 o.stall_cyc, o.din, init_word(32'h10));
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    obs_t o; int es, er, ee; logic [31:0] ed;
    bit we; int unsigned w, off; logic [31:0] addr, wd; int ack;
    for (int i = 0; i < 60; i++) begin
      we   = 1'($urandom_range(0, 1));
      w    = 32'h40 + $urandom_range(0, 7);
      off  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      addr = (w << 2) | off;
      wd   = $urandom;
      ack  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
      model_access(we, addr, wd, ack, es, er, ee, ed);
      run_access(we, addr, wd, ack, o);
      n_chk++;
      if (!o.done || !o.ram_ok)
        $display("FAIL rnd%0d_bus got done=%0d ram_ok=%0d exp 1/1", i, o.done, o.ram_ok);
      else n_pass++;
      n_chk++;
      if (o.stall_cyc !== es || o.req_cyc !== er || o.err_cyc !== ee)
        $display("FAIL rnd%0d_cyc got stall=%0d req=%0d err=%0d exp %0d/%0d/%0d", i,
                 o.stall_cyc, o.req_cyc, o.err_cyc, es, er, ee);
      else n_pass++;
      n_chk++;
      if (o.din !== ed) $display("FAIL rnd%0d_din got %h exp %h", i, o.din, ed); else n_pass++;
      if ($urandom_range(0, 2) == 0) begin
        idle_cycle();
        n_chk++;
        if (bif.mem_stall !== 1'b0 || bif.mem_err !== 1'b0 || bif.mem_din !== '0)
          $display("FAIL rnd%0d_idle got stall=%b err=%b din=%h exp 0", i, bif.mem_stall,
                   bif.mem_err, bif.mem_din);
        else n_pass++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_timeout();
    test_reset_mid();
`ifdef DMEM_RDBUF_EN
    test_rdbuf();
`else
    test_no_rdbuf();
`endif
    test_random();
    idle_cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
